// File: rtl/biss_slave_tx_if.sv
// Signal bundle between a BiSS-C slave transmitter and whatever drives its
// inputs and observes its outputs (testbench or surrounding encoder logic).
interface biss_slave_tx_if;
  logic [7:0]  BITS;
  logic [31:0] posn_i;
  logic        error_n_i;
  logic        warn_n_i;
  logic        ma_i;
  logic        slo_o;
  logic        busy_o;
  logic        done_o;
  logic        abort_o;

  modport slave (
    input  BITS, posn_i, error_n_i, warn_n_i, ma_i,
    output slo_o, busy_o, done_o, abort_o
  );

  modport master (
    output BITS, posn_i, error_n_i, warn_n_i, ma_i,
    input  slo_o, busy_o, done_o, abort_o
  );
endinterface

// File: rtl/biss_slave_tx.sv
// BiSS-C slave transmitter: answers MA clocks with ACK/START/CDS, a latched
// position word, error/warning flags and an inverted CRC6 on SLO.
module biss_slave_tx #(
  parameter int TIMEOUT_CYCLES = 250
) (
  input  logic            clk_i,
  input  logic            reset_i,
  biss_slave_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACK,
    S_START,
    S_CDS,
    S_DATA,
    S_ERR,
    S_WARN,
    S_CRC,
    S_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic             ma_s1_q, ma_s2_q, ma_dly_q;
  logic             slo_q, slo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [31:0]      posn_q, posn_d;
  logic [4:0]       top_q, top_d;
  logic             err_n_q, err_n_d;
  logic             warn_n_q, warn_n_d;
  logic [5:0]       crc_q, crc_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ma_rise;
  logic             ma_fall;
  logic             timeout_hit;
  logic [4:0]       bits_top;

  function automatic logic [5:0] crc_step(input logic [5:0] crc, input logic din);
    logic fb;
    fb = crc[5] ^ din;
    return {crc[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
  endfunction

  assign ma_rise = ma_s2_q & ~ma_dly_q;
  assign ma_fall = ~ma_s2_q & ma_dly_q;

  // A fall can never coincide with a hit because a hit needs MA high.
  assign timeout_hit = ma_s2_q && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Index of the MSB to send: 0 behaves as 1 bit, anything above 32 as 32.
  always_comb begin
    bits_top = 5'd0;
    if (bus.BITS > 8'd32) begin
      bits_top = 5'd31;
    end else if (bus.BITS != 8'd0) begin
      bits_top = 5'(bus.BITS - 8'd1);
    end
  end

  always_comb begin
    state_d  = state_q;
    slo_d    = slo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    posn_d   = posn_q;
    top_d    = top_q;
    err_n_d  = err_n_q;
    warn_n_d = warn_n_q;
    crc_d    = crc_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;

    if (state_q == S_IDLE || ma_fall || timeout_hit) begin
      cnt_d = '0;
    end else if (ma_s2_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        slo_d  = 1'b1;
        busy_d = 1'b0;
        if (ma_fall) begin
          posn_d   = bus.posn_i;
          top_d    = bits_top;
          err_n_d  = bus.error_n_i;
          warn_n_d = bus.warn_n_i;
          crc_d    = 6'd0;
          busy_d   = 1'b1;
          state_d  = S_ACK;
        end
      end

      default: begin
        if (timeout_hit) begin
          state_d = S_IDLE;
          slo_d   = 1'b1;
          busy_d  = 1'b0;
          if (state_q == S_TIMEOUT) begin
            done_d = 1'b1;
          end else begin
            abort_d = 1'b1;
          end
        end else if (ma_rise) begin
          case (state_q)
            S_ACK: begin
              slo_d   = 1'b0;
              state_d = S_START;
            end
            S_START: begin
              slo_d   = 1'b1;
              state_d = S_CDS;
            end
            S_CDS: begin
              slo_d   = 1'b0;
              idx_d   = top_q;
              state_d = S_DATA;
            end
            S_DATA: begin
              slo_d = posn_q[idx_q];
              crc_d = crc_step(crc_q, posn_q[idx_q]);
              if (idx_q == 5'd0) begin
                state_d = S_ERR;
              end else begin
                idx_d = idx_q - 5'd1;
              end
            end
            S_ERR: begin
              slo_d   = err_n_q;
              crc_d   = crc_step(crc_q, err_n_q);
              state_d = S_WARN;
            end
            S_WARN: begin
              slo_d   = warn_n_q;
              crc_d   = crc_step(crc_q, warn_n_q);
              idx_d   = 5'd5;
              state_d = S_CRC;
            end
            S_CRC: begin
              slo_d = ~crc_q[idx_q[2:0]];
              if (idx_q == 5'd0) begin
                state_d = S_TIMEOUT;
              end else begin
                idx_d = idx_q - 5'd1;
              end
            end
            S_TIMEOUT: begin
              slo_d = 1'b0;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Synchroniser idles high so a reset while MA is high creates no edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ma_s1_q  <= 1'b1;
      ma_s2_q  <= 1'b1;
      ma_dly_q <= 1'b1;
    end else begin
      ma_s1_q  <= bus.ma_i;
      ma_s2_q  <= ma_s1_q;
      ma_dly_q <= ma_s2_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      slo_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      posn_q   <= 32'd0;
      top_q    <= 5'd0;
      err_n_q  <= 1'b1;
      warn_n_q <= 1'b1;
      crc_q    <= 6'd0;
      idx_q    <= 5'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      slo_q    <= slo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      posn_q   <= posn_d;
      top_q    <= top_d;
      err_n_q  <= err_n_d;
      warn_n_q <= warn_n_d;
      crc_q    <= crc_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.slo_o   = slo_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.abort_o = abort_q;

endmodule

// File: tb/tb_biss_slave_tx.sv
// Self-checking bench for biss_slave_tx: stimulus pushes the expected SLO
// bit per MA rise into a queue, a monitor pops and compares after each rise.
module tb_biss_slave_tx;

  localparam int TIMEOUT_CYCLES = 250;
  localparam int HALF = 8;

  logic clk_i = 1'b0;
  logic reset_i;

  biss_slave_tx_if bus ();

  biss_slave_tx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string name;
    logic  val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   done_cnt  = 0;
  int   abort_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [5:0] crcRef(input logic [5:0] c, input logic b);
    logic fb;
    fb = c[5] ^ b;
    return {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
  endfunction

  always @(negedge clk_i) begin
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.abort_o === 1'b1) abort_cnt++;
  end

  // SLO must show the new bit on the 3rd clk edge after each MA rise.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge bus.ma_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput(e.name, 32'(bus.slo_o), 32'(e.val));
      end
    end
  end

  // Drives one frame; stop_after>0 leaves MA high after that many rises.
  task automatic applyStimulus(input logic [7:0] bits, input logic [31:0] posn,
                               input logic err_n, input logic warn_n,
                               input int stop_after, input logic [31:0] mid_posn,
                               input string tag);
    exp_t       lst[$];
    int         eb;
    int         n;
    logic [5:0] c;
    eb = (bits == 8'd0) ? 1 : (bits > 8'd32) ? 32 : int'(bits);
    lst.push_back(exp_t'{{tag, "_ack"}, 1'b0});
    lst.push_back(exp_t'{{tag, "_start"}, 1'b1});
    lst.push_back(exp_t'{{tag, "_cds"}, 1'b0});
    c = 6'd0;
    for (int i = eb - 1; i >= 0; i--) begin
      lst.push_back(exp_t'{$sformatf("%s_data[%0d]", tag, i), posn[i]});
      c = crcRef(c, posn[i]);
    end
    lst.push_back(exp_t'{{tag, "_err"}, err_n});
    c = crcRef(c, err_n);
    lst.push_back(exp_t'{{tag, "_warn"}, warn_n});
    c = crcRef(c, warn_n);
    for (int i = 5; i >= 0; i--) begin
      lst.push_back(exp_t'{$sformatf("%s_crc[%0d]", tag, i), ~c[i]});
    end
    lst.push_back(exp_t'{{tag, "_tmo_low"}, 1'b0});
    n = (stop_after > 0) ? stop_after : lst.size();
    for (int i = 0; i < n; i++) exp_q.push_back(lst[i]);

    @(negedge clk_i);
    bus.BITS      = bits;
    bus.posn_i    = posn;
    bus.error_n_i = err_n;
    bus.warn_n_i  = warn_n;
    bus.ma_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 checkOutput({tag, "_busy_pre"}, 32'(bus.busy_o), 32'd0);
    @(posedge clk_i);
    #1 checkOutput({tag, "_busy_set"}, 32'(bus.busy_o), 32'd1);
    repeat (HALF - 2) @(negedge clk_i);
    for (int i = 0; i < n; i++) begin
      bus.ma_i = 1'b1;
      if (i == 4) begin
        bus.posn_i    = mid_posn;
        bus.BITS      = ~bits;
        bus.error_n_i = ~err_n;
        bus.warn_n_i  = ~warn_n;
      end
      repeat (HALF) @(negedge clk_i);
      if (i < n - 1) begin
        bus.ma_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
      end
    end
  endtask

  // Waits (bounded) for the done/abort pulse that ends the frame.
  task automatic waitEnd(input logic expect_done, input string tag);
    int   d0;
    int   a0;
    int   k;
    int   bad_slo;
    logic seen;
    d0 = done_cnt;
    a0 = abort_cnt;
    k = 0;
    bad_slo = 0;
    seen = 1'b0;
    while (k < 400 && !seen) begin
      @(posedge clk_i);
      #1;
      k++;
      if (bus.done_o === 1'b1 || bus.abort_o === 1'b1) seen = 1'b1;
      else if (expect_done && bus.slo_o !== 1'b0) bad_slo++;
    end
    checkOutput({tag, "_end_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_end_delay"}, 32'(k), (k >= 240 && k <= 250) ? 32'(k) : 32'd244);
      checkOutput({tag, "_done"}, 32'(bus.done_o), 32'(expect_done));
      checkOutput({tag, "_abort"}, 32'(bus.abort_o), 32'(!expect_done));
      checkOutput({tag, "_slo_idle"}, 32'(bus.slo_o), 32'd1);
      checkOutput({tag, "_busy_clr"}, 32'(bus.busy_o), 32'd0);
      @(posedge clk_i);
      #1;
      checkOutput({tag, "_pulse_width"}, 32'({bus.done_o, bus.abort_o}), 32'd0);
    end
    if (expect_done) checkOutput({tag, "_tmo_slo_held"}, 32'(bad_slo), 32'd0);
    @(negedge clk_i);
    #1;
    checkOutput({tag, "_done_count"}, 32'(done_cnt - d0), 32'(expect_done));
    checkOutput({tag, "_abort_count"}, 32'(abort_cnt - a0), 32'(!expect_done));
    checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    reset_i       = 1'b0;
    bus.ma_i      = 1'b1;
    bus.BITS      = 8'd8;
    bus.posn_i    = 32'd0;
    bus.error_n_i = 1'b1;
    bus.warn_n_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_slo", 32'(bus.slo_o), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rst_done", 32'(bus.done_o), 32'd0);
    checkOutput("rst_abort", 32'(bus.abort_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (4) @(negedge clk_i);

    $display("[TB] frame BITS=8 posn=0xA5");
    applyStimulus(8'd8, 32'hA5, 1'b1, 1'b1, 0, 32'hA5, "a5");
    waitEnd(1'b1, "a5");

    $display("[TB] frame BITS=4 posn=0, CRC 0x05");
    applyStimulus(8'd4, 32'h0, 1'b1, 1'b1, 0, 32'hF, "b4");
    waitEnd(1'b1, "b4");

    $display("[TB] width boundaries");
    applyStimulus(8'd32, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 32'h0, "w32");
    waitEnd(1'b1, "w32");
    applyStimulus(8'd0, 32'h0000_0002, 1'b1, 1'b0, 0, 32'h1, "w0");
    waitEnd(1'b1, "w0");
    applyStimulus(8'd40, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 32'h0, "w40");
    waitEnd(1'b1, "w40");

    $display("[TB] abort after 5th data bit");
    applyStimulus(8'd16, 32'h5A5A, 1'b1, 1'b0, 8, 32'h5A5A, "abt");
    waitEnd(1'b0, "abt");
    applyStimulus(8'd16, 32'h5A5A, 1'b1, 1'b0, 0, 32'h0, "post_abt");
    waitEnd(1'b1, "post_abt");

    $display("[TB] input change while busy");
    applyStimulus(8'd8, 32'h12, 1'b1, 1'b1, 0, 32'h34, "p12");
    waitEnd(1'b1, "p12");
    applyStimulus(8'd8, 32'h34, 1'b1, 1'b1, 0, 32'h34, "p34");
    waitEnd(1'b1, "p34");

    $display("[TB] asynchronous reset mid-DATA");
    applyStimulus(8'd16, 32'hA000, 1'b1, 1'b1, 7, 32'hA000, "ar");
    @(posedge clk_i);
    #2 reset_i = 1'b0;
    #1;
    checkOutput("ar_async_slo", 32'(bus.slo_o), 32'd1);
    checkOutput("ar_async_busy", 32'(bus.busy_o), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    repeat (4) @(negedge clk_i);
    applyStimulus(8'd8, 32'h3C, 1'b0, 1'b0, 0, 32'hC3, "post_ar");
    waitEnd(1'b1, "post_ar");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
